// File: rtl/xcoef_pkg.sv
// Shared types and reset values for the crosstalk-coefficient loader.
package xcoef_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    APPLY = 2'd2
  } xcoef_state_t;

  localparam logic [31:0] COEF_ONE = 32'h7FFF_0000;

  // Identity-matrix value for flat entry k of an ndac x ndac matrix.
  function automatic logic [31:0] identity(input int unsigned k, input int unsigned ndac);
    return ((k / ndac) == (k % ndac)) ? COEF_ONE : 32'h0000_0000;
  endfunction

endpackage

// File: rtl/xcoef_bank.sv
// NDAC x NDAC coefficient register array with write port, bulk load and optional readback.
// Readback is present only when XCOEF_READBACK_EN is defined.
module xcoef_bank
  import xcoef_pkg::*;
#(
  parameter int unsigned NDAC   = 4,
  parameter int unsigned CWIDTH = 32,
  parameter int unsigned AW     = $clog2(NDAC * NDAC)
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          we,
  input  logic [AW-1:0]                 waddr,
  input  logic [CWIDTH-1:0]             wdata,
  input  logic                          load,
  input  logic [NDAC*NDAC*CWIDTH-1:0]   load_data,
  input  logic [AW-1:0]                 rd_addr,
  output logic [CWIDTH-1:0]             rd_data,
  output logic [NDAC*NDAC*CWIDTH-1:0]   q
);

  localparam int unsigned N = NDAC * NDAC;

  logic [CWIDTH-1:0] mem_q [N];

  // Bulk load wins over a single write; the top never asserts both.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k < N; k++) begin
        mem_q[k] <= CWIDTH'(identity(k, NDAC));
      end
    end else if (load) begin
      for (int k = 0; k < N; k++) begin
        mem_q[k] <= load_data[k*CWIDTH +: CWIDTH];
      end
    end else if (we && (32'(waddr) < N)) begin
      mem_q[waddr] <= wdata;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_flat
    assign q[g*CWIDTH +: CWIDTH] = mem_q[g];
  end

`ifdef XCOEF_READBACK_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_data <= '0;
    end else if (32'(rd_addr) < N) begin
      rd_data <= mem_q[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^rd_addr;
  assign rd_data        = '0;
`endif

endmodule

// File: rtl/xcoef_loader.sv
// Shadow/active crosstalk-coefficient loader with frame-aligned atomic commit.
// Shadow readback port is functional only when XCOEF_READBACK_EN is defined.
module xcoef_loader
  import xcoef_pkg::*;
#(
  parameter int unsigned NDAC   = 4,
  parameter int unsigned CWIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            wr_en,
  input  logic [$clog2(NDAC*NDAC)-1:0]    wr_addr,
  input  logic [CWIDTH-1:0]               wr_data,
  input  logic                            commit,
  input  logic                            frame_sync,
  output logic                            busy,
  output logic                            wr_err,
  output logic [NDAC*NDAC*CWIDTH-1:0]     coef,
  output logic                            coef_update,
  input  logic [$clog2(NDAC*NDAC)-1:0]    rd_addr,
  output logic [CWIDTH-1:0]               rd_data
);

  localparam int unsigned AW = $clog2(NDAC * NDAC);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_PEND  = PEND;
  localparam logic [1:0] ST_APPLY = APPLY;

  logic [1:0] state_q, state_d;
  logic       wr_err_q, wr_err_d;
  logic       idle;

  logic [NDAC*NDAC*CWIDTH-1:0] shadow_q;
  logic [CWIDTH-1:0]           active_rd_unused;

  assign idle = (state_q == ST_IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (commit) state_d = ST_PEND;
      ST_PEND:  if (frame_sync) state_d = ST_APPLY;
      ST_APPLY: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_err_d = wr_err_q;
    if (!idle && wr_en) begin
      wr_err_d = 1'b1;
    end else if (idle && commit) begin
      wr_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_err_q <= wr_err_d;
    end
  end

  assign busy        = !idle;
  assign wr_err      = wr_err_q;
  assign coef_update = (state_q == ST_APPLY);

  // Writes land only while idle, so a same-cycle write+commit is included in the bank.
  xcoef_bank #(
    .NDAC   (NDAC),
    .CWIDTH (CWIDTH),
    .AW     (AW)
  ) u_shadow (
    .clk       (clk),
    .rstn      (rstn),
    .we        (wr_en && idle),
    .waddr     (wr_addr),
    .wdata     (wr_data),
    .load      (1'b0),
    .load_data ('0),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .q         (shadow_q)
  );

  // Active bank takes the whole shadow in the APPLY cycle; new coef is visible the cycle after.
  xcoef_bank #(
    .NDAC   (NDAC),
    .CWIDTH (CWIDTH),
    .AW     (AW)
  ) u_active (
    .clk       (clk),
    .rstn      (rstn),
    .we        (1'b0),
    .waddr     ('0),
    .wdata     ('0),
    .load      (coef_update),
    .load_data (shadow_q),
    .rd_addr   ('0),
    .rd_data   (active_rd_unused),
    .q         (coef)
  );

endmodule

// File: tb/tb_xcoef_loader.sv
// Self-checking bench for xcoef_loader: vector table plus commit scoreboard.
module tb_xcoef_loader;

  localparam int unsigned NDAC   = 4;
  localparam int unsigned CWIDTH = 32;
  localparam int unsigned N      = NDAC * NDAC;
  localparam int unsigned AW     = 4;

  typedef logic [N*CWIDTH-1:0] snap_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [31:0]   exp_coef;
  } vec_t;

  logic              clk = 1'b0;
  logic              rstn;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [31:0]       wr_data;
  logic              commit;
  logic              frame_sync;
  logic              busy;
  logic              wr_err;
  logic [N*32-1:0]   coef;
  logic              coef_update;
  logic [AW-1:0]     rd_addr;
  logic [31:0]       rd_data;

  always #5 clk = ~clk;

  xcoef_loader #(
    .NDAC   (NDAC),
    .CWIDTH (CWIDTH)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .commit      (commit),
    .frame_sync  (frame_sync),
    .busy        (busy),
    .wr_err      (wr_err),
    .coef        (coef),
    .coef_update (coef_update),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] sh  [N];
  logic [31:0] act [N];
  snap_t       exp_q [$];
  vec_t        vecs [5];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] ident(input int k);
    return ((k / 4) == (k % 4)) ? 32'h7FFF_0000 : 32'h0;
  endfunction

  function automatic logic [31:0] coef_at(input int k);
    return coef[k*32 +: 32];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      sh[k]  = ident(k);
      act[k] = ident(k);
    end
    exp_q.delete();
  endtask

  task automatic push_snapshot();
    snap_t s;
    for (int k = 0; k < N; k++) s[k*32 +: 32] = sh[k];
    exp_q.push_back(s);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input bit lands);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    if (lands) sh[a] = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    push_snapshot();
    step();
    commit = 1'b0;
  endtask

  // Pulse frame_sync, wait (bounded) for coef_update, then score the committed bank.
  task automatic apply_and_check(input string name);
    bit    got;
    snap_t s;
    got = 1'b0;
    frame_sync = 1'b1;
    step();
    frame_sync = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (coef_update === 1'b1) begin
        got = 1'b1;
        break;
      end
      step();
    end
    check({name, " coef_update seen"}, 32'(got), 32'd1);
    if (got) begin
      for (int k = 0; k < N; k++) check({name, " coef old during update"}, coef_at(k), act[k]);
      step();
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s: scoreboard empty, got 0 entries, expected 1", name);
      end else begin
        s = exp_q.pop_front();
        for (int k = 0; k < N; k++) begin
          check({name, " coef after update"}, coef_at(k), s[k*32 +: 32]);
          act[k] = s[k*32 +: 32];
        end
      end
      check({name, " coef_update one cycle"}, 32'(coef_update), 32'd0);
      check({name, " busy after apply"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rstn       = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    commit     = 1'b0;
    frame_sync = 1'b0;
    rd_addr    = '0;
    model_reset();

    // Reset state
    step();
    step();
    check("reset coef0", coef_at(0), 32'h7FFF_0000);
    check("reset coef1", coef_at(1), 32'h0000_0000);
    check("reset coef5", coef_at(5), 32'h7FFF_0000);
    for (int k = 0; k < N; k++) check("reset coef identity", coef_at(k), ident(k));
    check("reset busy", 32'(busy), 32'd0);
    check("reset wr_err", 32'(wr_err), 32'd0);
    check("reset coef_update", 32'(coef_update), 32'd0);
    check("reset rd_data", rd_data, 32'd0);
    rstn = 1'b1;
    step();

    // Table-driven writes, one commit, check each entry lands after the apply
    vecs[0] = '{addr: 4'd1,  data: 32'h1234_ABCD, exp_coef: 32'h1234_ABCD};
    vecs[1] = '{addr: 4'd6,  data: 32'h8000_7FFF, exp_coef: 32'h8000_7FFF};
    vecs[2] = '{addr: 4'd15, data: 32'h0001_FFFF, exp_coef: 32'h0001_FFFF};
    vecs[3] = '{addr: 4'd10, data: 32'hCAFE_0001, exp_coef: 32'hCAFE_0001};
    vecs[4] = '{addr: 4'd0,  data: 32'h0000_0000, exp_coef: 32'h0000_0000};
    for (int i = 0; i < 5; i++) do_write(vecs[i].addr, vecs[i].data, 1'b1);
    do_commit();
    check("commit busy", 32'(busy), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("pend coef1 unchanged", coef_at(1), 32'h0000_0000);
      check("pend no coef_update", 32'(coef_update), 32'd0);
      step();
    end
    apply_and_check("table");
    for (int i = 0; i < 5; i++) check("table entry", coef_at(int'(vecs[i].addr)), vecs[i].exp_coef);
    step();
    step();
    check("table coef1 holds", coef_at(1), 32'h1234_ABCD);

    // Write while pending is dropped and flagged
    do_commit();
    do_write(4'd2, 32'h0000_0001, 1'b0);
    check("pend write wr_err", 32'(wr_err), 32'd1);
    apply_and_check("pend write");
    check("pend write coef2", coef_at(2), 32'h0000_0000);
    check("wr_err sticky", 32'(wr_err), 32'd1);
    do_commit();
    check("commit clears wr_err", 32'(wr_err), 32'd0);
    apply_and_check("clear commit");

    // Same-cycle write+commit+frame_sync, then commit while busy is ignored
    wr_en      = 1'b1;
    wr_addr    = 4'd3;
    wr_data    = 32'h4000_0000;
    commit     = 1'b1;
    frame_sync = 1'b1;
    sh[3]      = 32'h4000_0000;
    push_snapshot();
    step();
    wr_en      = 1'b0;
    commit     = 1'b0;
    frame_sync = 1'b0;
    check("same-cycle busy", 32'(busy), 32'd1);
    check("same-cycle no apply", 32'(coef_update), 32'd0);
    step();
    check("same-cycle still pend", 32'(coef_update), 32'd0);
    commit = 1'b1;
    step();
    commit = 1'b0;
    apply_and_check("same-cycle");
    check("same-cycle coef3", coef_at(3), 32'h4000_0000);
    frame_sync = 1'b1;
    step();
    frame_sync = 1'b0;
    check("busy commit ignored update", 32'(coef_update), 32'd0);
    check("busy commit ignored busy", 32'(busy), 32'd0);

    // Reset while pending discards the commit and restores identity
    do_write(4'd1, 32'h5555_5555, 1'b1);
    do_commit();
    check("pre-reset busy", 32'(busy), 32'd1);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    model_reset();
    check("mid reset busy", 32'(busy), 32'd0);
    check("mid reset wr_err", 32'(wr_err), 32'd0);
    check("mid reset coef1", coef_at(1), 32'h0000_0000);
    check("mid reset coef0", coef_at(0), 32'h7FFF_0000);
    frame_sync = 1'b1;
    step();
    frame_sync = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("post reset no coef_update", 32'(coef_update), 32'd0);
      step();
    end
    do_commit();
    apply_and_check("post reset shadow identity");

    // Shadow readback
    do_write(4'd7, 32'hDEAD_BEEF, 1'b1);
    rd_addr = 4'd7;
    step();
`ifdef XCOEF_READBACK_EN
    check("readback entry7", rd_data, 32'hDEAD_BEEF);
`else
    check("readback disabled", rd_data, 32'h0000_0000);
`endif
    rd_addr = 4'd5;
    step();
`ifdef XCOEF_READBACK_EN
    check("readback entry5", rd_data, 32'h7FFF_0000);
`else
    check("readback disabled 5", rd_data, 32'h0000_0000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
